kftvga_text_fetch: RTL and testbench

//   Video-side reader of the text VRAM. Converts the timing generator's pixel position into

---
 rtl/kftvga_text_fetch.sv | 154 +++++++++++++++
 tb/tb_kftvga_text_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kftvga_text_fetch.sv
// Text-mode fetch pipeline: pixel position -> VRAM address -> font row -> 4-bit palette index.
// Three register stages (address, font lookup, colour); strobes are delayed alongside the pixel.
module kftvga_text_fetch #(
    parameter int   COLUMNS    = 80,
    parameter int   ROWS       = 60,
    parameter int   CURSOR_TOP = 6,
    parameter int   CURSOR_BIT = 4,
    parameter int   BLINK_BIT  = 5,
    parameter logic VSYNC_ACT  = 1'b0
) (
    input  logic        video_clock,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        display_en_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [12:0] video_address,
    input  logic [15:0] video_data_out,
    output logic [10:0] font_address,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    output logic [3:0]  pixel_color,
    output logic        display_en_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam logic [6:0]  COLS_LIM = 7'(COLUMNS);
    localparam logic [6:0]  ROWS_LIM = 7'(ROWS);
    localparam logic [12:0] STRIDE   = 13'(COLUMNS);
    localparam logic [2:0]  CUR_TOP  = 3'(CURSOR_TOP);

    logic [6:0]  col_in;
    logic [6:0]  row_in;
    logic        in_range;
    logic [12:0] row_mul;

    assign col_in   = pixel_x[9:3];
    assign row_in   = pixel_y[9:3];
    assign in_range = display_en_in && (col_in < COLS_LIM) && (row_in < ROWS_LIM);

    // row * COLUMNS as a sum of shifted copies, one per set bit of the stride
    always_comb begin
        row_mul = '0;
        for (int i = 0; i < 13; i++) begin
            if (STRIDE[i]) begin
                row_mul = row_mul + (13'(row_in) << i);
            end
        end
    end

    // Stage 0 state
    logic [6:0] col_s0;
    logic [6:0] row_s0;
    logic [2:0] line_s0;
    logic [2:0] bit_s0;
    logic       blank_s0;
    logic       de_s0;
    logic       hs_s0;
    logic       vs_s0;

    // Stage 1 state
    logic [7:0] attr_s1;
    logic [2:0] bit_s1;
    logic       blank_s1;
    logic       hit_s1;
    logic       de_s1;
    logic       hs_s1;
    logic       vs_s1;

    logic [7:0] frame_count;
    logic       cursor_hit;
    logic       pix_on;
    logic [3:0] color_next;

    assign cursor_hit = cursor_en && (col_s0 == cursor_col) && (row_s0 == {1'b0, cursor_row})
                        && (line_s0 >= CUR_TOP);

    always_comb begin
        pix_on = font_data[3'd7 - bit_s1];
        if (attr_s1[7] && frame_count[BLINK_BIT]) begin
            pix_on = 1'b0;
        end
        // the cursor overrides blinking so it stays visible on blinking cells
        if (hit_s1 && !frame_count[CURSOR_BIT]) begin
            pix_on = 1'b1;
        end
        if (blank_s1) begin
            color_next = 4'h0;
        end else if (pix_on) begin
            color_next = attr_s1[3:0];
        end else begin
            color_next = {1'b0, attr_s1[6:4]};
        end
    end

    always_ff @(posedge video_clock or negedge reset_n) begin
        if (!reset_n) begin
            col_s0         <= '0;
            row_s0         <= '0;
            line_s0        <= '0;
            bit_s0         <= '0;
            blank_s0       <= 1'b0;
            de_s0          <= 1'b0;
            hs_s0          <= 1'b0;
            vs_s0          <= 1'b0;
            video_address  <= '0;
            attr_s1        <= '0;
            font_address   <= '0;
            bit_s1         <= '0;
            blank_s1       <= 1'b0;
            hit_s1         <= 1'b0;
            de_s1          <= 1'b0;
            hs_s1          <= 1'b0;
            vs_s1          <= 1'b0;
            pixel_color    <= '0;
            display_en_out <= 1'b0;
            hsync_out      <= 1'b0;
            vsync_out      <= 1'b0;
            frame_count    <= '0;
        end else begin
            col_s0        <= col_in;
            row_s0        <= row_in;
            line_s0       <= pixel_y[2:0];
            bit_s0        <= pixel_x[2:0];
            blank_s0      <= !in_range;
            de_s0         <= display_en_in;
            hs_s0         <= hsync_in;
            vs_s0         <= vsync_in;
            video_address <= in_range ? (row_mul + 13'(col_in)) : 13'd0;

            attr_s1      <= video_data_out[15:8];
            font_address <= {video_data_out[7:0], line_s0};
            bit_s1       <= bit_s0;
            blank_s1     <= blank_s0;
            hit_s1       <= cursor_hit;
            de_s1        <= de_s0;
            hs_s1        <= hs_s0;
            vs_s1        <= vs_s0;

            pixel_color    <= color_next;
            display_en_out <= de_s1;
            hsync_out      <= hs_s1;
            vsync_out      <= vs_s1;

            // stage-0 and stage-1 copies of vsync form the edge detector
            if ((vs_s0 == VSYNC_ACT) && (vs_s1 != VSYNC_ACT)) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_kftvga_text_fetch.sv
// Bench for kftvga_text_fetch: behavioural VRAM/font model, address table, hand-written
// corner sequences and a randomized run scored against an arithmetic reference model.
module tb_kftvga_text_fetch;
    logic        video_clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        display_en_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [12:0] video_address;
    logic [15:0] video_data_out = '0;
    logic [10:0] font_address;
    logic [7:0]  font_data;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [3:0]  pixel_color;
    logic        display_en_out;
    logic        hsync_out;
    logic        vsync_out;

    kftvga_text_fetch dut (
        .video_clock    (video_clock),
        .reset_n        (reset_n),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .display_en_in  (display_en_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .video_address  (video_address),
        .video_data_out (video_data_out),
        .font_address   (font_address),
        .font_data      (font_data),
        .cursor_en      (cursor_en),
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .pixel_color    (pixel_color),
        .display_en_out (display_en_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out)
    );

    always #5 video_clock = ~video_clock;

    // Memories: VRAM registers on the falling edge, font ROM is combinational
    logic [15:0] vram [0:4799];
    logic [7:0]  font_rom [0:2047];

    always @(negedge video_clock)
        video_data_out <= (video_address < 13'd4800) ? vram[video_address] : 16'h0;
    assign font_data = font_rom[font_address];

    typedef struct {
        logic       chk;
        logic [6:0] val;   // {color, de, hs, vs}
    } exp_t;

    typedef struct {
        int   x;
        int   y;
        logic de;
        int   addr;
    } vec_t;

    exp_t       exp_q[$];
    logic [3:0] obs[$];
    int         errors = 0;
    int         checks = 0;
    int         model_count = 0;
    logic       model_prev_vs = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int model_addr(input int x, input int y, input logic de);
        int col = x / 8;
        int row = y / 8;
        return (de && col < 80 && row < 60) ? row * 80 + col : 0;
    endfunction

    function automatic logic [6:0] model_pixel(input int x, input int y, input logic de,
                                               input logic hs, input logic vs);
        int         col = x / 8;
        int         row = y / 8;
        logic [15:0] w;
        logic [7:0]  fr;
        logic [7:0]  attr;
        logic [7:0]  mc;
        logic        on;
        logic        hit;
        logic [3:0]  color;
        color = 4'h0;
        mc = 8'(model_count);
        if (de && col < 80 && row < 60) begin
            w    = vram[row * 80 + col];
            attr = w[15:8];
            fr   = font_rom[int'(w[7:0]) * 8 + y % 8];
            on   = fr[7 - x % 8];
            if (attr[7] && mc[5]) on = 1'b0;
            hit = cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && (y % 8) >= 6;
            if (hit && !mc[4]) on = 1'b1;
            color = on ? attr[3:0] : {1'b0, attr[6:4]};
        end
        return {color, de, hs, vs};
    endfunction

    task automatic step(input int x, input int y, input logic de, input logic hs, input logic vs);
        exp_t e;
        pixel_x       = 10'(x);
        pixel_y       = 10'(y);
        display_en_in = de;
        hsync_in      = hs;
        vsync_in      = vs;
        if (model_prev_vs == 1'b1 && vs == 1'b0) model_count = (model_count + 1) % 256;
        model_prev_vs = vs;
        exp_q.push_back('{chk: 1'b1, val: model_pixel(x, y, de, hs, vs)});
        @(posedge video_clock);
        #1;
        chk("addr", int'(video_address), model_addr(x, y, de));
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            obs.push_back(pixel_color);
            if (e.chk) chk("pix", int'({pixel_color, display_en_out, hsync_out, vsync_out}), int'(e.val));
        end
    endtask

    task automatic flush();
        repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic vpulse();
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_addr", int'(video_address), 0);
        chk("rst_font", int'(font_address), 0);
        chk("rst_out", int'({pixel_color, display_en_out, hsync_out, vsync_out}), 0);
        repeat (2) @(posedge video_clock);
        @(negedge video_clock);
        reset_n = 1'b1;
        exp_q.delete();
        obs.delete();
        exp_q.push_back('{chk: 1'b0, val: 7'h0});
        exp_q.push_back('{chk: 1'b0, val: 7'h0});
        model_count   = 0;
        model_prev_vs = 1'b0;
    endtask

    vec_t       tbl[10];
    logic [3:0] t2_exp[8];

    initial begin
        for (int i = 0; i < 4800; i++) vram[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);

        tbl[0] = '{x: 100, y: 50,  de: 1'b1, addr: 492};
        tbl[1] = '{x: 639, y: 479, de: 1'b1, addr: 4799};
        tbl[2] = '{x: 640, y: 0,   de: 1'b1, addr: 0};
        tbl[3] = '{x: 0,   y: 0,   de: 1'b1, addr: 0};
        tbl[4] = '{x: 7,   y: 8,   de: 1'b1, addr: 80};
        tbl[5] = '{x: 8,   y: 0,   de: 1'b1, addr: 1};
        tbl[6] = '{x: 0,   y: 480, de: 1'b1, addr: 0};
        tbl[7] = '{x: 632, y: 472, de: 1'b1, addr: 4799};
        tbl[8] = '{x: 300, y: 200, de: 1'b1, addr: 2037};
        tbl[9] = '{x: 100, y: 50,  de: 1'b0, addr: 0};

        // Reset while the timing generator is mid-frame, then the address table
        pixel_x = 10'd100;
        pixel_y = 10'd50;
        display_en_in = 1'b1;
        #2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].x, tbl[i].y, tbl[i].de, 1'b1, 1'b1);
            chk("tbl_addr", int'(video_address), tbl[i].addr);
        end

        // Cell (0,0): word 0x1E41, font row 0xF0
        flush();
        vram[0] = 16'h1E41;
        font_rom[{8'h41, 3'd0}] = 8'hF0;
        flush();
        t2_exp = '{4'hE, 4'hE, 4'hE, 4'hE, 4'h1, 4'h1, 4'h1, 4'h1};
        obs.delete();
        for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) chk("cell00", int'(obs[i + 2]), int'(t2_exp[i]));

        // Columns past 639 stay blank even with display enabled
        obs.delete();
        step(700, 8, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        chk("x_oob", int'(obs[2]), 0);

        // Underline cursor at (3,2)
        vram[2 * 80 + 3] = 16'h0720;
        for (int l = 0; l < 8; l++) font_rom[{8'h20, 3'(l)}] = 8'h00;
        vram[5] = 16'h9F01;
        for (int l = 0; l < 8; l++) font_rom[{8'h01, 3'(l)}] = 8'hFF;
        cursor_en  = 1'b1;
        cursor_col = 7'd3;
        cursor_row = 6'd2;
        flush();
        obs.delete();
        for (int l = 0; l < 8; l++)
            for (int x = 24; x < 32; x++) step(x, 16 + l, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        for (int l = 0; l < 8; l++)
            for (int k = 0; k < 8; k++)
                chk("cursor", int'(obs[2 + l * 8 + k]), (l >= 6) ? 7 : 0);

        // Blink attribute, frame_count bit 5 clear -> foreground
        obs.delete();
        step(40, 0, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        chk("blink_fc0", int'(obs[2]), 15);

        // 16 frames: cursor phase bit set -> cursor hidden
        repeat (16) vpulse();
        obs.delete();
        step(24, 23, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        chk("cursor_fc16", int'(obs[2]), 0);

        // 32 frames: blink bit set, cursor bit clear
        repeat (16) vpulse();
        obs.delete();
        step(40, 0, 1'b1, 1'b1, 1'b1);
        step(24, 23, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        chk("blink_fc32", int'(obs[2]), 1);
        chk("cursor_fc32", int'(obs[3]), 7);

        // Randomized run against the reference model
        cursor_col = 7'($urandom_range(0, 79));
        cursor_row = 6'($urandom_range(0, 59));
        cursor_en  = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int   x;
            int   y;
            logic vs;
            if ($urandom_range(0, 3) == 0) begin
                x = int'(cursor_col) * 8 + int'($urandom_range(0, 7));
                y = int'(cursor_row) * 8 + int'($urandom_range(0, 7));
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 600));
            end
            vs = ($urandom_range(0, 3) == 0) ? ~vsync_in : vsync_in;
            step(x, y, 1'($urandom_range(0, 7) != 0), 1'($urandom), vs);
        end

        // Asynchronous reset in the middle of a line clears everything
        step(41, 0, 1'b1, 1'b1, 1'b1);
        step(42, 0, 1'b1, 1'b1, 1'b1);
        #3;
        do_reset();
        cursor_en = 1'b0;
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        obs.delete();
        step(40, 0, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        chk("fc_after_rst", int'(obs[2]), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
